// File: rtl/udp_tx_noc_in_deframe.sv
// Deframes UDP_TX_SEGMENT NoC messages into a header record plus a tagged payload beat stream.
// Define UDP_TX_NOC_IN_CHECK_EN to enable header sanity checking that drives udp_tx_in_err.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef NOC_DATA_BYTES
`define NOC_DATA_BYTES 64
`endif
`ifndef NOC_DATA_BYTES_W
`define NOC_DATA_BYTES_W 6
`endif
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef PORT_NUM_W
`define PORT_NUM_W 16
`endif
`ifndef UDP_LENGTH_W
`define UDP_LENGTH_W 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 22
`endif
`ifndef UDP_TX_SEGMENT
`define UDP_TX_SEGMENT 8'h1c
`endif

module udp_tx_noc_in_deframe #(
    parameter int SRC_X = -1,
    parameter int SRC_Y = -1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          noc0_ctovr_udp_tx_in_val,
    input  logic [`NOC_DATA_WIDTH-1:0]    noc0_ctovr_udp_tx_in_data,
    output logic                          udp_tx_in_noc0_ctovr_rdy,
    output logic                          udp_tx_in_hdr_val,
    output logic [`IP_ADDR_W-1:0]         udp_tx_in_src_ip,
    output logic [`IP_ADDR_W-1:0]         udp_tx_in_dst_ip,
    output logic [`PORT_NUM_W-1:0]        udp_tx_in_src_port,
    output logic [`PORT_NUM_W-1:0]        udp_tx_in_dst_port,
    output logic [`UDP_LENGTH_W-1:0]      udp_tx_in_len,
    input  logic                          udp_tx_in_hdr_rdy,
    output logic                          udp_tx_in_data_val,
    output logic [`MAC_INTERFACE_W-1:0]   udp_tx_in_data,
    output logic                          udp_tx_in_data_last,
    output logic [`MAC_PADBYTES_W-1:0]    udp_tx_in_data_padbytes,
    input  logic                          udp_tx_in_data_rdy,
    output logic                          udp_tx_in_err
);
    localparam int W   = `NOC_DATA_WIDTH;
    localparam int MLW = `MSG_LENGTH_WIDTH;

    typedef enum logic [1:0] {StWaitHdr, StWaitMeta, StHdrOut, StData} state_e;

    state_e state_q, state_d;

    logic [`IP_ADDR_W-1:0]    src_ip_q, dst_ip_q;
    logic [`PORT_NUM_W-1:0]   src_port_q, dst_port_q;
    logic [`UDP_LENGTH_W-1:0] len_q;
    logic [MLW-1:0]           flits_rem_q;

    // Metadata flit fields, packed from the MSB down
    logic [`IP_ADDR_W-1:0]    meta_src_ip, meta_dst_ip;
    logic [`PORT_NUM_W-1:0]   meta_src_port, meta_dst_port;
    logic [`UDP_LENGTH_W-1:0] meta_len;
    logic [MLW-1:0]           meta_flits;

    assign meta_src_ip   = noc0_ctovr_udp_tx_in_data[W-1  -: `IP_ADDR_W];
    assign meta_dst_ip   = noc0_ctovr_udp_tx_in_data[W-33 -: `IP_ADDR_W];
    assign meta_src_port = noc0_ctovr_udp_tx_in_data[W-65 -: `PORT_NUM_W];
    assign meta_dst_port = noc0_ctovr_udp_tx_in_data[W-81 -: `PORT_NUM_W];
    assign meta_len      = noc0_ctovr_udp_tx_in_data[W-97 -: `UDP_LENGTH_W];
    assign meta_flits    = MLW'(meta_len >> `NOC_DATA_BYTES_W)
                         + MLW'(meta_len[`NOC_DATA_BYTES_W-1:0] != '0);

    logic hdr_hs, meta_hs, data_hs, noc_rdy;
    logic [`MAC_PADBYTES_W-1:0] pad_last;

    assign hdr_hs   = (state_q == StWaitHdr) && noc0_ctovr_udp_tx_in_val;
    assign meta_hs  = (state_q == StWaitMeta) && noc0_ctovr_udp_tx_in_val;
    assign data_hs  = (state_q == StData) && noc0_ctovr_udp_tx_in_val && udp_tx_in_data_rdy;
    // 64 - 0 truncates to 0, so full final beats report no padding
    assign pad_last = `MAC_PADBYTES_W'(`NOC_DATA_BYTES - int'(len_q[`NOC_DATA_BYTES_W-1:0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWaitHdr;
            src_ip_q    <= '0;
            dst_ip_q    <= '0;
            src_port_q  <= '0;
            dst_port_q  <= '0;
            len_q       <= '0;
            flits_rem_q <= '0;
        end else begin
            state_q <= state_d;
            if (meta_hs) begin
                src_ip_q    <= meta_src_ip;
                dst_ip_q    <= meta_dst_ip;
                src_port_q  <= meta_src_port;
                dst_port_q  <= meta_dst_port;
                len_q       <= meta_len;
                flits_rem_q <= meta_flits;
            end else if (data_hs) begin
                flits_rem_q <= flits_rem_q - MLW'(1);
            end
        end
    end

    always_comb begin
        state_d                 = state_q;
        noc_rdy                 = 1'b0;
        udp_tx_in_hdr_val       = 1'b0;
        udp_tx_in_data_val      = 1'b0;
        udp_tx_in_data_last     = 1'b0;
        udp_tx_in_data_padbytes = '0;
        unique case (state_q)
            StWaitHdr: begin
                noc_rdy = 1'b1;
                if (noc0_ctovr_udp_tx_in_val) state_d = StWaitMeta;
            end
            StWaitMeta: begin
                noc_rdy = 1'b1;
                if (noc0_ctovr_udp_tx_in_val) state_d = StHdrOut;
            end
            StHdrOut: begin
                udp_tx_in_hdr_val = 1'b1;
                if (udp_tx_in_hdr_rdy) begin
                    state_d = (flits_rem_q == '0) ? StWaitHdr : StData;
                end
            end
            StData: begin
                noc_rdy             = udp_tx_in_data_rdy;
                udp_tx_in_data_val  = noc0_ctovr_udp_tx_in_val;
                udp_tx_in_data_last = (flits_rem_q == MLW'(1));
                if (udp_tx_in_data_last) udp_tx_in_data_padbytes = pad_last;
                if (data_hs && udp_tx_in_data_last) state_d = StWaitHdr;
            end
            default: state_d = StWaitHdr;
        endcase
    end

    // Hold off the NoC while reset is asserted even though the reset state is WAIT_HDR
    assign udp_tx_in_noc0_ctovr_rdy = noc_rdy & ~rst;
    assign udp_tx_in_src_ip         = src_ip_q;
    assign udp_tx_in_dst_ip         = dst_ip_q;
    assign udp_tx_in_src_port       = src_port_q;
    assign udp_tx_in_dst_port       = dst_port_q;
    assign udp_tx_in_len            = len_q;
    assign udp_tx_in_data           = `MAC_INTERFACE_W'(noc0_ctovr_udp_tx_in_data);

`ifdef UDP_TX_NOC_IN_CHECK_EN
    localparam logic [7:0] SrcXB = 8'(SRC_X);
    localparam logic [7:0] SrcYB = 8'(SRC_Y);

    logic [7:0]     hdr_dst_x_q, hdr_dst_y_q, hdr_type_q, hdr_mflits_q;
    logic [MLW-1:0] hdr_msg_len_q;
    logic           hdr_bad, err_q;

    // Header flit fields, packed from the MSB down
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_dst_x_q   <= '0;
            hdr_dst_y_q   <= '0;
            hdr_msg_len_q <= '0;
            hdr_type_q    <= '0;
            hdr_mflits_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            if (hdr_hs) begin
                hdr_dst_x_q   <= noc0_ctovr_udp_tx_in_data[W-1  -: 8];
                hdr_dst_y_q   <= noc0_ctovr_udp_tx_in_data[W-9  -: 8];
                hdr_msg_len_q <= noc0_ctovr_udp_tx_in_data[W-17 -: MLW];
                hdr_type_q    <= noc0_ctovr_udp_tx_in_data[W-39 -: 8];
                hdr_mflits_q  <= noc0_ctovr_udp_tx_in_data[W-47 -: 8];
            end
            if (meta_hs && hdr_bad) err_q <= 1'b1;
        end
    end

    assign hdr_bad = (hdr_dst_x_q != SrcXB) || (hdr_dst_y_q != SrcYB)
                  || (hdr_type_q != `UDP_TX_SEGMENT) || (hdr_mflits_q != 8'd1)
                  || (hdr_msg_len_q != meta_flits + MLW'(1));
    assign udp_tx_in_err = err_q;
`else
    logic unused_hdr_hs;
    assign unused_hdr_hs = hdr_hs;
    assign udp_tx_in_err = 1'b0;
`endif

endmodule

// File: tb/tb_udp_tx_noc_in_deframe.sv
// Randomised bench for udp_tx_noc_in_deframe with a queue-based message model and directed pins.
module tb_udp_tx_noc_in_deframe;
    localparam int W = 512;
    localparam logic [7:0] SEG = 8'h1c;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          noc_val = 1'b0;
    logic [W-1:0]  noc_data = '0;
    logic          noc_rdy;
    logic          hdr_val;
    logic [31:0]   src_ip, dst_ip;
    logic [15:0]   src_port, dst_port, len_o;
    logic          hdr_rdy = 1'b0;
    logic          data_val;
    logic [W-1:0]  data;
    logic          last;
    logic [5:0]    pad;
    logic          data_rdy = 1'b0;
    logic          err;

    udp_tx_noc_in_deframe dut (
        .clk                        (clk),
        .rst                        (rst),
        .noc0_ctovr_udp_tx_in_val   (noc_val),
        .noc0_ctovr_udp_tx_in_data  (noc_data),
        .udp_tx_in_noc0_ctovr_rdy   (noc_rdy),
        .udp_tx_in_hdr_val          (hdr_val),
        .udp_tx_in_src_ip           (src_ip),
        .udp_tx_in_dst_ip           (dst_ip),
        .udp_tx_in_src_port         (src_port),
        .udp_tx_in_dst_port         (dst_port),
        .udp_tx_in_len              (len_o),
        .udp_tx_in_hdr_rdy          (hdr_rdy),
        .udp_tx_in_data_val         (data_val),
        .udp_tx_in_data             (data),
        .udp_tx_in_data_last        (last),
        .udp_tx_in_data_padbytes    (pad),
        .udp_tx_in_data_rdy         (data_rdy),
        .udp_tx_in_err              (err)
    );

    typedef struct {
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [15:0] len;
    } hdr_t;
    typedef struct {
        logic [W-1:0] d;
        logic         last;
        logic [5:0]   pad;
    } beat_t;

    hdr_t  hq[$];
    beat_t dq[$];
    int    tests = 0;
    int    fails = 0;
    bit    err_exp = 1'b0;
    int    rdy_mode = 0;
    int    hv_cnt = 0;
    int    obs_beats = 0;
    logic        obs_last = 1'b0;
    logic [5:0]  obs_pad = '0;
    logic [15:0] obs_len = '0, obs_sp = '0, obs_dp = '0;

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] rnd_flit();
        logic [W-1:0] f;
        for (int i = 0; i < W / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    function automatic logic [W-1:0] mk_hdr(logic [21:0] mlen, logic [7:0] mtype);
        logic [W-1:0] f = rnd_flit();
        f[W-1  -: 8]  = 8'hff;
        f[W-9  -: 8]  = 8'hff;
        f[W-17 -: 22] = mlen;
        f[W-39 -: 8]  = mtype;
        f[W-47 -: 8]  = 8'd1;
        return f;
    endfunction

    function automatic logic [W-1:0] mk_meta(hdr_t h);
        logic [W-1:0] f = rnd_flit();
        f[W-1  -: 32] = h.sip;
        f[W-33 -: 32] = h.dip;
        f[W-65 -: 16] = h.sp;
        f[W-81 -: 16] = h.dp;
        f[W-97 -: 16] = h.len;
        return f;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the flit is taken
    task automatic send_flit(input logic [W-1:0] d);
        bit ok = 1'b0;
        noc_val  = 1'b1;
        noc_data = d;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (noc_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) chk("noc_accept_timeout", ok, 1);
    endtask

    // stop_after >= 0 abandons the message after that many payload beats
    task automatic send_msg(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                            input logic [15:0] dp, input int len, input bit bad_type,
                            input int mlen_ovr, input int stop_after);
        hdr_t         h;
        int           n = (len + 63) / 64;
        logic [W-1:0] beats[$];
        int           mlen;
        h.sip = sip; h.dip = dip; h.sp = sp; h.dp = dp; h.len = 16'(len);
        hq.push_back(h);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.d    = rnd_flit();
            b.last = (i == n - 1);
            b.pad  = b.last ? 6'((64 - len % 64) % 64) : 6'd0;
            beats.push_back(b.d);
            dq.push_back(b);
        end
        mlen = (mlen_ovr >= 0) ? mlen_ovr : 1 + n;
        send_flit(mk_hdr(22'(mlen), bad_type ? (SEG ^ 8'h01) : SEG));
        send_flit(mk_meta(h));
`ifdef UDP_TX_NOC_IN_CHECK_EN
        if (bad_type || mlen != 1 + n) err_exp = 1'b1;
`endif
        for (int i = 0; i < n; i++) begin
            if (i == stop_after) return;
            send_flit(beats[i]);
        end
        noc_val = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && (hq.size() != 0 || dq.size() != 0); i++) @(posedge clk);
        #1;
        chk("drain_pending", 32'(hq.size() + dq.size()), 0);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: begin
                hdr_rdy  = 1'b1;
                data_rdy = 1'b1;
            end
            1: begin
                hdr_rdy  = 1'($urandom_range(0, 1));
                data_rdy = 1'($urandom_range(0, 1));
            end
            default: begin
                hv_cnt   = hdr_val ? hv_cnt + 1 : 0;
                hdr_rdy  = (hv_cnt > 5);
                data_rdy = ~data_rdy;
            end
        endcase
    end

    beat_t cb;
    always @(negedge clk) begin
        if (!rst) begin
            chk("err", err, err_exp);
            if (hq.size() == 0 && dq.size() != 0) begin
                chk("data_val_passthru", data_val, noc_val);
                chk("noc_rdy_mirror", noc_rdy, data_rdy);
            end
            if (hq.size() != 0) chk("data_during_hdr", data_val, 0);
            if (hdr_val) begin
                chk("noc_rdy_in_hdr", noc_rdy, 0);
                if (hq.size() == 0) chk("hdr_unexpected", hdr_val, 0);
                else begin
                    chk("hdr_src_ip", src_ip, hq[0].sip);
                    chk("hdr_dst_ip", dst_ip, hq[0].dip);
                    chk("hdr_src_port", src_port, hq[0].sp);
                    chk("hdr_dst_port", dst_port, hq[0].dp);
                    chk("hdr_len", len_o, hq[0].len);
                    if (hdr_rdy) begin
                        obs_len = len_o;
                        obs_sp  = src_port;
                        obs_dp  = dst_port;
                        void'(hq.pop_front());
                    end
                end
            end
            if (data_val && data_rdy) begin
                if (dq.size() == 0) chk("beat_unexpected", data_val, 0);
                else begin
                    cb = dq.pop_front();
                    chk("beat_data", data, cb.d);
                    chk("beat_last", last, cb.last);
                    chk("beat_pad", pad, cb.pad);
                    obs_beats++;
                    obs_last = last;
                    obs_pad  = pad;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_noc_rdy", noc_rdy, 0);
        chk("rst_hdr_val", hdr_val, 0);
        chk("rst_data_val", data_val, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_noc_rdy", noc_rdy, 1);
        chk("idle_hdr_val", hdr_val, 0);
        chk("idle_err", err, 0);
        @(posedge clk);
        #1;

        rdy_mode  = 0;
        obs_beats = 0;
        send_msg(32'h0a000001, 32'h0a000002, 16'h1234, 16'h5678, 64, 1'b0, -1, -1);
        wait_idle();
        chk("t64_len", obs_len, 64);
        chk("t64_sport", obs_sp, 16'h1234);
        chk("t64_dport", obs_dp, 16'h5678);
        chk("t64_beats", obs_beats, 1);
        chk("t64_last", obs_last, 1);
        chk("t64_pad", obs_pad, 0);

        obs_beats = 0;
        send_msg(32'hc0a80001, 32'hc0a80002, 16'd1000, 16'd2000, 100, 1'b0, -1, -1);
        wait_idle();
        chk("t100_beats", obs_beats, 2);
        chk("t100_pad", obs_pad, 28);

        obs_beats = 0;
        send_msg(32'h01020304, 32'h05060708, 16'd7, 16'd9, 0, 1'b0, -1, -1);
        send_msg(32'h01020304, 32'h05060708, 16'd7, 16'd9, 1, 1'b0, -1, -1);
        wait_idle();
        chk("t0_1_beats", obs_beats, 1);
        chk("t1_pad", obs_pad, 63);
        chk("t1_len", obs_len, 1);

        rdy_mode = 2;
        send_msg(32'h11111111, 32'h22222222, 16'd11, 16'd22, 200, 1'b0, -1, -1);
        send_msg(32'h33333333, 32'h44444444, 16'd33, 16'd44, 130, 1'b0, -1, -1);
        wait_idle();

        rdy_mode = 1;
        for (int m = 0; m < 25; m++) begin
            send_msg($urandom, $urandom, 16'($urandom), 16'($urandom),
                     int'($urandom_range(0, 300)), 1'b0, -1, -1);
        end
        wait_idle();

        rdy_mode = 0;
        send_msg(32'haaaa0001, 32'hbbbb0002, 16'd5, 16'd6, 256, 1'b0, -1, 2);
        rst = 1'b1;
        hq.delete();
        dq.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_data_val", data_val, 0);
        chk("abort_hdr_val", hdr_val, 0);
        chk("abort_noc_rdy", noc_rdy, 0);
        @(posedge clk);
        #1;
        noc_val = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        chk("abort_idle_rdy", noc_rdy, 1);
        @(posedge clk);
        #1;
        obs_beats = 0;
        send_msg(32'h0badcafe, 32'hfeedf00d, 16'd77, 16'd88, 70, 1'b0, -1, -1);
        wait_idle();
        chk("fresh_beats", obs_beats, 2);
        chk("fresh_pad", obs_pad, 58);

        obs_beats = 0;
        send_msg(32'h12345678, 32'h87654321, 16'd1, 16'd2, 64, 1'b1, -1, -1);
        wait_idle();
        chk("badtype_beats", obs_beats, 1);
        obs_beats = 0;
        send_msg(32'h12345678, 32'h87654321, 16'd1, 16'd2, 64, 1'b0, 3, -1);
        wait_idle();
        chk("badlen_beats", obs_beats, 1);
        send_msg(32'h12345678, 32'h87654321, 16'd1, 16'd2, 10, 1'b0, -1, -1);
        wait_idle();
`ifdef UDP_TX_NOC_IN_CHECK_EN
        chk("err_sticky", err, 1);
`else
        chk("err_tied_low", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
